// File: rtl/noise_lfo_seq_pkg.sv
// Shared constants, FSM encoding and LFSR step function for the noise LFO sequencer.
// The same lfsr_next() is used by the filter bank's verification model, so both ends
// agree on the noise sequence.
package noise_lfo_seq_pkg;

  localparam int NOISE_NCH = 32;
  localparam int NOISE_DSZ = 18;
  localparam logic [NOISE_DSZ-1:0] NOISE_TAPS = 18'h20400;  // x^18 + x^11 + 1
  localparam logic [NOISE_DSZ-1:0] NOISE_SEED = 18'h00001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } noise_state_t;

  // Right-shifting Galois step; the caller handles the all-zero lockup state.
  function automatic logic [NOISE_DSZ-1:0] lfsr_next(input logic [NOISE_DSZ-1:0] s);
    return (s >> 1) ^ (s[0] ? NOISE_TAPS : '0);
  endfunction

endpackage

// File: rtl/noise_lfo_seq_lfsr_step.sv
// Combinational Galois LFSR step with zero-lock recovery.
// Ports:
//   s     in   DSZ  current LFSR state
//   seed  in   DSZ  channel seed, used when s has collapsed to zero
//   nxt   out  DSZ  next LFSR state
module noise_lfsr_step
  import noise_lfo_seq_pkg::*;
#(
  parameter int               DSZ  = NOISE_DSZ,
  parameter logic [DSZ-1:0]   TAPS = NOISE_TAPS
) (
  input  logic [DSZ-1:0] s,
  input  logic [DSZ-1:0] seed,
  output logic [DSZ-1:0] nxt
);

  logic [DSZ-1:0] galois;

  // Default configuration reuses the package step so RTL and models share one source.
  if (DSZ == NOISE_DSZ && TAPS == NOISE_TAPS) begin : g_pkg_step
    assign galois = lfsr_next(s);
  end else begin : g_generic_step
    assign galois = (s >> 1) ^ ({DSZ{s[0]}} & TAPS);
  end

  // A zero state would lock the register forever; reload the channel seed instead.
  assign nxt = (s == '0) ? seed : galois;

endmodule

// File: rtl/noise_lfo_seq.sv
// Time-multiplexed 32-channel LFSR noise source feeding a shared noise IIR filter bank.
// On each tick it walks channels 0..31 (one per clk), advances each channel's LFSR,
// drives the filter with noise/select/enable and captures the filter output per channel.
// Ports:
//   clk          in   1    system clock
//   rst          in   1    asynchronous reset, active-high
//   tick         in   1    sample-rate strobe
//   f_in         out  DSZ  signed noise sample to the filter
//   f_sel        out  5    filter channel select
//   f_ena        out  1    filter state update enable
//   f_out        in   DSZ  signed filter output for the selected channel
//   rd_sel       in   5    readback channel
//   rd_data      out  DSZ  captured filter value of rd_sel (1-clk latency)
//   busy         out  1    scan in progress
//   frame_done   out  1    one-clk pulse after the last channel is captured
//   overrun      out  1    sticky: tick seen while a frame was still running
//   overrun_clr  in   1    clears overrun (a same-cycle overrun set wins)
module noise_lfo_seq
  import noise_lfo_seq_pkg::*;
#(
  parameter int             DSZ  = NOISE_DSZ,
  parameter int             NCH  = NOISE_NCH,
  parameter logic [DSZ-1:0] SEED = NOISE_SEED,
  parameter logic [DSZ-1:0] TAPS = NOISE_TAPS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  output logic signed [DSZ-1:0] f_in,
  output logic [4:0]            f_sel,
  output logic                  f_ena,
  input  logic signed [DSZ-1:0] f_out,
  input  logic [4:0]            rd_sel,
  output logic signed [DSZ-1:0] rd_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam logic [4:0] LAST_CH = 5'(NCH - 1);

  noise_state_t          state_reg;
  noise_state_t          state_next;
  logic [4:0]            ch_reg;
  logic [DSZ-1:0]        lfsr_reg [NCH];
  logic signed [DSZ-1:0] cap_reg  [NCH];
  logic [DSZ-1:0]        seed_tbl [NCH];
  logic signed [DSZ-1:0] rd_data_reg;
  logic                  overrun_reg;
  logic [DSZ-1:0]        lfsr_nxt;

  // Per-channel reset seeds: SEED + i, wrapping, with zero forced to 1.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_seed
    localparam logic [DSZ-1:0] SEED_SUM = SEED + DSZ'(gi);
    assign seed_tbl[gi] = (SEED_SUM == '0) ? DSZ'(1) : SEED_SUM;
  end

  noise_lfsr_step #(
    .DSZ  (DSZ),
    .TAPS (TAPS)
  ) u_step (
    .s    (lfsr_reg[ch_reg]),
    .seed (seed_tbl[ch_reg]),
    .nxt  (lfsr_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Outputs are decoded from the state register so an async reset drops f_ena at once.
  always_comb begin
    state_next = state_reg;
    f_ena      = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    f_in       = '0;
    case (state_reg)
      ST_IDLE: begin
        if (tick) state_next = ST_SCAN;
      end
      ST_SCAN: begin
        f_ena = 1'b1;
        busy  = 1'b1;
        f_in  = $signed(lfsr_nxt);
        if (ch_reg == LAST_CH) state_next = ST_DONE;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Channel counter parks on the last channel; only a fresh frame start rewinds it,
  // which also makes f_sel hold its last value outside of a scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_reg <= '0;
    end else if (state_reg == ST_IDLE && tick) begin
      ch_reg <= '0;
    end else if (state_reg == ST_SCAN && ch_reg != LAST_CH) begin
      ch_reg <= ch_reg + 5'd1;
    end
  end

  assign f_sel = ch_reg;

  // Capture takes f_out before the filter applies this cycle's update: one frame latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        lfsr_reg[i] <= seed_tbl[i];
        cap_reg[i]  <= '0;
      end
    end else if (state_reg == ST_SCAN) begin
      lfsr_reg[ch_reg] <= lfsr_nxt;
      cap_reg[ch_reg]  <= f_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= cap_reg[rd_sel];
    end
  end

  assign rd_data = rd_data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_reg <= 1'b0;
    end else if (tick && state_reg != ST_IDLE) begin
      overrun_reg <= 1'b1;
    end else if (overrun_clr) begin
      overrun_reg <= 1'b0;
    end
  end

  assign overrun = overrun_reg;

endmodule
